// File: rtl/analog_seq_pkg.sv
// rtl/analog_seq_pkg.sv - shared defaults, state encoding and channel search helper
package analog_seq_pkg;

    localparam int BIAS_CYC_DEF = 16;
    localparam int SAMPLE_N_DEF = 8;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_BIAS_UP = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_SAMPLE  = 3'd3;
    localparam state_t ST_DECIDE  = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Lowest enabled channel at or above 'from'; bit 2 set means none left
    function automatic logic [2:0] next_chan(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/analog_seq_ctrl_if.sv
// rtl/analog_seq_ctrl_if.sv - host-side control/status interface of the sequencer
interface analog_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       ack;
    logic [3:0] chan_mask;
    logic [3:0] settle_cfg;
    logic [3:0] result;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, ack, chan_mask, settle_cfg,
        input  result, busy, done
    );

    modport slave (
        input  start, abort, ack, chan_mask, settle_cfg,
        output result, busy, done
    );
endinterface

// File: rtl/analog_seq_ctrl_comp_sync.sv
// rtl/analog_seq_ctrl_comp_sync.sv - two-flop synchronizer for the raw comparator output
module comp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two back-to-back flops resolve metastability of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/analog_seq_ctrl.sv
// rtl/analog_seq_ctrl.sv - bias/settle/sample/decide sequencer for a 4-channel comparator front end
module analog_seq_ctrl
    import analog_seq_pkg::*;
#(
    parameter int BIAS_CYC = BIAS_CYC_DEF,
    parameter int SAMPLE_N = SAMPLE_N_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    analog_seq_ctrl_if.slave        host,
    input  logic                    comp_in,
    output logic                    bias_en,
    output logic                    comp_en,
    output logic [1:0]              mux_sel,
    output logic                    latch_set,
    output logic                    latch_rst
);
    localparam int         CNT_W       = $clog2(SAMPLE_N) + 1;
    localparam logic [7:0] BIAS_LAST   = 8'(BIAS_CYC - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_N - 1);

    state_t           state_q, state_d;
    logic [7:0]       tmr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       mask_q;
    logic [3:0]       settle_q;
    logic [3:0]       result_q;
    logic [1:0]       ch_q;
    logic             comp_s;
    logic             busy;
    logic             dec;
    logic [2:0]       from;
    logic [2:0]       nxt;

    comp_sync u_comp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (comp_in),
        .q_o   (comp_s)
    );

    assign busy = (state_q == ST_BIAS_UP) || (state_q == ST_SETTLE) ||
                  (state_q == ST_SAMPLE)  || (state_q == ST_DECIDE);
    assign dec  = cnt_q > CNT_W'(SAMPLE_N / 2);
    // Leaving BIAS_UP searches from channel 0, leaving DECIDE from the one above
    assign from = (state_q == ST_BIAS_UP) ? 3'd0 : ({1'b0, ch_q} + 3'd1);
    assign nxt  = next_chan(mask_q, from);

    // Next-state selection; abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (host.start && (host.chan_mask != 4'd0)) state_d = ST_BIAS_UP;
            ST_BIAS_UP: if (tmr_q == BIAS_LAST) state_d = ST_SETTLE;
            ST_SETTLE:  if (tmr_q == {4'd0, settle_q}) state_d = ST_SAMPLE;
            ST_SAMPLE:  if (tmr_q == SAMPLE_LAST) state_d = ST_DECIDE;
            ST_DECIDE:  state_d = nxt[2] ? ST_DONE : ST_SETTLE;
            ST_DONE:    if (host.ack) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && host.abort) begin
            state_d = ST_IDLE;
        end
    end

    // State, phase timer, sample counter, captured config, channel and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmr_q    <= 8'd0;
            cnt_q    <= '0;
            mask_q   <= 4'd0;
            settle_q <= 4'd0;
            result_q <= 4'd0;
            ch_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            tmr_q   <= (busy && (state_d == state_q)) ? tmr_q + 8'd1 : 8'd0;

            if ((state_d == ST_IDLE) || (state_q == ST_DECIDE)) begin
                cnt_q <= '0;
            end else if ((state_q == ST_SAMPLE) && comp_s) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if ((state_q == ST_IDLE) && (state_d == ST_BIAS_UP)) begin
                mask_q   <= host.chan_mask;
                settle_q <= host.settle_cfg;
                result_q <= 4'd0;
            end

            if ((state_q == ST_BIAS_UP) && (state_d == ST_SETTLE)) begin
                ch_q <= nxt[1:0];
            end

            if ((state_q == ST_DECIDE) && !host.abort) begin
                result_q[ch_q] <= dec;
                if (state_d == ST_SETTLE) begin
                    ch_q <= nxt[1:0];
                end
            end
        end
    end

    assign bias_en     = busy;
    assign comp_en     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_DECIDE);
    assign mux_sel     = ch_q;
    assign latch_rst   = (state_q == ST_BIAS_UP) && (tmr_q == 8'd0);
    assign latch_set   = (state_q == ST_DECIDE) && dec;
    assign host.result = result_q;
    assign host.busy   = busy;
    assign host.done   = (state_q == ST_DONE);
endmodule

// File: tb/tb_analog_seq_ctrl.sv
// tb/tb_analog_seq_ctrl.sv - directed vector bench for analog_seq_ctrl
module tb_analog_seq_ctrl;
    localparam int BIAS = 16;

    logic       clk;
    logic       rst_n;
    logic       comp_in;
    logic       bias_en;
    logic       comp_en;
    logic [1:0] mux_sel;
    logic       latch_set;
    logic       latch_rst;

    int total;
    int bad;

    analog_seq_ctrl_if host_if ();

    analog_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host_if),
        .comp_in   (comp_in),
        .bias_en   (bias_en),
        .comp_en   (comp_en),
        .mux_sel   (mux_sel),
        .latch_set (latch_set),
        .latch_rst (latch_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       mask;
        logic [3:0]       settle;
        logic [3:0][7:0]  samp;
        logic [3:0]       exp_result;
        int               exp_done;
        int               exp_sets;
        int               abort_at;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   done_cyc;
        int   n_rst;
        int   n_set;
        int   ord;
        int   s0;
        int   k;
        int   last_ch;
        logic c;
        @(negedge clk);
        host_if.chan_mask  = v.mask;
        host_if.settle_cfg = v.settle;
        host_if.start      = 1'b1;
        @(negedge clk);
        host_if.start      = 1'b0;
        host_if.chan_mask  = ~v.mask;
        host_if.settle_cfg = ~v.settle;
        done_cyc = -1;
        n_rst    = 0;
        n_set    = 0;
        last_ch  = 0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (latch_rst) n_rst++;
            if (latch_set) n_set++;
            ord = 0;
            c   = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                if (v.mask[ch]) begin
                    s0 = BIAS + ord * (v.settle + 10);
                    if (cyc == s0) begin
                        check($sformatf("v%0d_mux_ch%0d", idx, ch), int'(mux_sel), ch);
                        check($sformatf("v%0d_comp_en_ch%0d", idx, ch), int'(comp_en), 1);
                    end
                    k = cyc + 2 - (s0 + v.settle + 1);
                    if (k >= 0 && k < 8) c = v.samp[ch][k];
                    last_ch = ch;
                    ord++;
                end
            end
            if (v.abort_at >= 0 && cyc == v.abort_at + 1) begin
                check($sformatf("v%0d_abort_busy", idx), int'(host_if.busy), 0);
                check($sformatf("v%0d_abort_bias", idx), int'(bias_en), 0);
                check($sformatf("v%0d_abort_comp", idx), int'(comp_en), 0);
                check($sformatf("v%0d_abort_result", idx), int'(host_if.result), int'(v.exp_result));
                break;
            end
            if (host_if.done) begin
                done_cyc = cyc;
                break;
            end
            comp_in       = c;
            host_if.abort = (cyc == v.abort_at);
            host_if.start = (cyc == 5);
            @(negedge clk);
        end
        comp_in       = 1'b0;
        host_if.abort = 1'b0;
        host_if.start = 1'b0;
        check($sformatf("v%0d_latch_rst_cnt", idx), n_rst, 1);
        check($sformatf("v%0d_latch_set_cnt", idx), n_set, v.exp_sets);
        if (v.abort_at < 0) begin
            check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
            if (done_cyc >= 0) begin
                check($sformatf("v%0d_result", idx), int'(host_if.result), int'(v.exp_result));
                check($sformatf("v%0d_done_bias", idx), int'({bias_en, comp_en, host_if.busy}), 0);
                check($sformatf("v%0d_done_mux_hold", idx), int'(mux_sel), last_ch);
                host_if.start     = 1'b1;
                host_if.chan_mask = 4'hF;
                @(negedge clk);
                host_if.start = 1'b0;
                check($sformatf("v%0d_done_start_ign", idx), int'({host_if.done, host_if.busy}), 2);
                check($sformatf("v%0d_done_hold_res", idx), int'(host_if.result), int'(v.exp_result));
                host_if.ack = 1'b1;
                @(negedge clk);
                host_if.ack = 1'b0;
                check($sformatf("v%0d_ack_idle", idx), int'({host_if.done, host_if.busy}), 0);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        comp_in            = 1'b0;
        host_if.start      = 1'b0;
        host_if.abort      = 1'b0;
        host_if.ack        = 1'b0;
        host_if.chan_mask  = 4'd0;
        host_if.settle_cfg = 4'd0;

        vecs[0] = '{4'b0001, 4'd3,  {8'h00, 8'h00, 8'h00, 8'hFF}, 4'b0001, 29,  1, -1};
        vecs[1] = '{4'b1010, 4'd3,  {8'hFF, 8'h00, 8'h00, 8'h00}, 4'b1000, 42,  1, -1};
        vecs[2] = '{4'b0001, 4'd0,  {8'h00, 8'h00, 8'h00, 8'h0F}, 4'b0000, 26,  0, -1};
        vecs[3] = '{4'b0001, 4'd0,  {8'h00, 8'h00, 8'h00, 8'hAD}, 4'b0001, 26,  1, -1};
        vecs[4] = '{4'b1111, 4'd15, {8'hF7, 8'h0F, 8'h1F, 8'hFF}, 4'b1011, 116, 3, -1};
        vecs[5] = '{4'b0100, 4'd1,  {8'h00, 8'hE0, 8'h00, 8'h00}, 4'b0000, 27,  0, -1};
        vecs[6] = '{4'b0111, 4'd0,  {8'h00, 8'hFF, 8'h00, 8'hFF}, 4'b0001, -1,  1, 40};

        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({bias_en, comp_en, mux_sel, latch_set, latch_rst, host_if.result, host_if.busy, host_if.done}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", int'({host_if.busy, host_if.done}), 0);

        host_if.start     = 1'b1;
        host_if.chan_mask = 4'd0;
        @(negedge clk);
        host_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("zero_mask_busy", int'(host_if.busy), 0);
        check("zero_mask_bias", int'(bias_en), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        @(negedge clk);
        host_if.chan_mask  = 4'b0001;
        host_if.settle_cfg = 4'd5;
        host_if.start      = 1'b1;
        @(negedge clk);
        host_if.start = 1'b0;
        repeat (18) @(negedge clk);
        check("settle_bias_on", int'({bias_en, comp_en}), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bias", int'({bias_en, comp_en}), 0);
        check("async_rst_busy", int'(host_if.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_result", int'(host_if.result), 0);
        check("rst_release_idle", int'({host_if.busy, host_if.done}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/analog_seq_ctrl.md
ANALOG_SEQ_CTRL -- requirements
Module: analog_seq_ctrl

Interface
REQ-001 Parameter BIAS_CYC, default 16, SHALL set the bias warm-up length in cycles (range 1..255).
REQ-002 Parameter SAMPLE_N, default 8, SHALL set the comparator samples per channel (power of two, 2..64).
REQ-003 clk  in  1  single clock; all state SHALL be on the rising edge.
REQ-004 rst_n  in  1  reset SHALL be asynchronous and active-low.
REQ-005 start  in  1  sequence request, sampled in IDLE.
REQ-006 abort  in  1  synchronous abort, honoured in any non-IDLE state.
REQ-007 chan_mask  in  4  enabled mux channels, bit i = channel i.
REQ-008 settle_cfg  in  4  per-channel settle length minus one.
REQ-009 comp_in  in  1  raw asynchronous comparator output.
REQ-010 ack  in  1  result acknowledge.
REQ-011 bias_en  out  1  bias block enable.
REQ-012 comp_en  out  1  comparator enable.
REQ-013 mux_sel  out  2  analog mux select (S1,S0).
REQ-014 latch_set  out  1  one-cycle trip-latch set pulse.
REQ-015 latch_rst  out  1  one-cycle trip-latch reset pulse.
REQ-016 result  out  4  per-channel majority decision.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 done  out  1  high only in DONE.

Function
REQ-019 States SHALL be IDLE, BIAS_UP, SETTLE, SAMPLE, DECIDE, DONE.
REQ-020 IDLE: start=1 with chan_mask!=0 SHALL capture chan_mask and settle_cfg, clear result, and enter BIAS_UP; start with chan_mask==0 SHALL be ignored.
REQ-021 BIAS_UP: bias_en=1 for exactly BIAS_CYC cycles; latch_rst=1 on its first cycle only; then SETTLE on the lowest enabled channel.
REQ-022 SETTLE: bias_en=1, comp_en=1, mux_sel=current channel, for captured settle_cfg+1 cycles, then SAMPLE.
REQ-023 SAMPLE: for SAMPLE_N cycles, count cycles where synchronized comp_in=1 (counter width log2(SAMPLE_N)+1, no wrap).
REQ-024 DECIDE (1 cycle): result[ch] <= (count > SAMPLE_N/2); latch_set equals that bit this cycle; count clears.
REQ-025 After DECIDE, the next higher enabled captured channel SHALL enter SETTLE; if none, enter DONE.
REQ-026 DONE: bias_en=0, comp_en=0, done=1, result stable; ack=1 SHALL return to IDLE next cycle; start in DONE ignored.
REQ-027 start while busy SHALL be ignored; mid-sequence chan_mask/settle_cfg changes SHALL have no effect.
REQ-028 abort (outside IDLE) SHALL enter IDLE next cycle, dropping bias_en/comp_en, with result holding completed channels only; abort has priority over ack.
REQ-029 mux_sel SHALL hold its last value outside SETTLE/SAMPLE/DECIDE.
REQ-030 comp_in SHALL pass a 2-flop synchronizer before counting.

Reset
REQ-031 During rst_n=0: state=IDLE, all outputs 0, counters, captured config and synchronizer flops 0.
REQ-032 Reset mid-sequence SHALL drop bias_en/comp_en immediately without waiting for a clock.

Structure
REQ-033 Package analog_seq_pkg SHALL hold the state enum and BIAS_CYC/SAMPLE_N defaults.
REQ-034 Sub-module comp_sync (2-flop synchronizer, async active-low reset) SHALL be instantiated once.

Verification
REQ-035 mask=0001, settle_cfg=3, comp_in=1 -> done rises 29 cycles after BIAS_UP entry; result=0001; one latch_rst and one latch_set pulse.
REQ-036 mask=1010, comp_in=0 on ch1, 1 on ch3 -> mux_sel 1 then 3; result=1000; latch_set only during ch3 DECIDE.
REQ-037 comp_in high exactly 4 of 8 sample cycles -> result bit 0; high 5 of 8 -> 1.
REQ-038 abort during ch2 SAMPLE (mask=0111, ch0 tripped) -> IDLE next cycle, bias_en=0, result=0001.
REQ-039 start with mask=0000 -> stays IDLE; start pulses while busy -> single sequence only.
REQ-040 rst_n low during SETTLE -> bias_en/comp_en 0 asynchronously; after release IDLE, result=0000.
